fifo_lane_adder: RTL and testbench
==================================

FIFO_LANE_ADDER -- requirements
Module: fifo_lane_adder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the FIFO word width.
REQ-002 The block SHALL have parameter OP_WIDTH, default 4, giving the operand width per lane.
REQ-003 The block SHALL have parameter LANES, default 2, giving the operand pairs per word; legal only if DATA_WIDTH >= 2*LANES*OP_WIDTH and DATA_WIDTH >= LANES*(OP_WIDTH+1).
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 data_empty  input  1  input FIFO empty; first-word-fall-through, so data_din is valid whenever low.
REQ-007 data_rd  output  1  input FIFO pop, one-cycle pulse.
REQ-008 data_din  input  DATA_WIDTH  input FIFO word.
REQ-009 data_full  input  1  output FIFO full.
REQ-010 data_wr  output  1  output FIFO push, one-cycle pulse.
REQ-011 data_dout  output  DATA_WIDTH  packed lane results.
REQ-012 mode  input  2  operation: 00 add, 01 subtract, 10 saturating add, 11 reserved (behaves as add).
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 result_count  output  16  number of words written since reset.

Function
REQ-015 The FSM SHALL have three states (IDLE, CALC, WRITE), all outputs registered.
REQ-016 IDLE, data_empty low: the block SHALL set data_rd=1, capture data_din and mode into operand registers, and go to CALC.
REQ-017 IDLE, data_empty high: the block SHALL stay in IDLE with data_rd=0.
REQ-018 Lane i operand a SHALL be data_din[2i*OP_WIDTH +: OP_WIDTH] and operand b SHALL be data_din[(2i+1)*OP_WIDTH +: OP_WIDTH], both unsigned.
REQ-019 CALC: the block SHALL compute all lanes into a result register and go to WRITE.
REQ-020 Add: the lane result SHALL be a+b, OP_WIDTH+1 bits, with no overflow loss.
REQ-021 Subtract: the lane result SHALL be a-b, two's complement, OP_WIDTH+1 bits.
REQ-022 Saturating add: the lane result SHALL be min(a+b, 2^OP_WIDTH-1), zero-extended to OP_WIDTH+1 bits.
REQ-023 Lane i result SHALL occupy data_dout[i*(OP_WIDTH+1) +: OP_WIDTH+1]; all higher data_dout bits SHALL be 0.
REQ-024 WRITE, data_full low: the block SHALL set data_wr=1, drive data_dout with the result, increment result_count, and go to IDLE.
REQ-025 WRITE, data_full high: the block SHALL hold in WRITE with data_wr=0, retaining the result with no loss, until data_full is low.
REQ-026 data_rd and data_wr SHALL each default to 0 every cycle unless set by REQ-016 or REQ-024.
REQ-027 Latency: data_wr SHALL go high exactly 2 cycles after data_rd when data_full is low; throughput SHALL be one word per 3 cycles.
REQ-028 mode SHALL be sampled only at capture; a mode change mid-operation SHALL NOT affect the word in flight.
REQ-029 data_dout SHALL hold its last written value between writes.
REQ-030 result_count SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-031 While reset_n is low at a rising edge, the block SHALL set state=IDLE, data_rd=0, data_wr=0, data_dout=0, result_count=0, busy=0 and clear the operand and result registers.
REQ-032 Reset in CALC or WRITE SHALL abort the word in flight with no data_wr for it; reset has priority over all other events.

Verification
REQ-033 With defaults, mode=00, data_din=0x00004321: data_rd pulses once, then 2 cycles later data_wr pulses with data_dout=0x000000E3 and result_count=1.
REQ-034 With mode=01, data_din=0x00004321: data_dout=0x000003FF (both lanes -1).
REQ-035 With data_din=0x000000FF: mode=00 gives data_dout=0x0000001E; mode=10 gives data_dout=0x0000000F.
REQ-036 With data_full held high for 5 cycles in WRITE: data_wr stays 0 and busy stays 1; data_wr pulses on the cycle after data_full falls, with the correct value.
REQ-037 With 4 back-to-back words and data_empty low throughout: data_rd pulses are 3 cycles apart, there are 4 data_wr pulses, and result_count=4.
REQ-038 With reset_n low for one cycle while in CALC: no data_wr occurs, all outputs are 0, and the next word is processed normally.

Source files
------------

// File: rtl/fifo_lane_adder_if.sv
// FIFO-side handshake bundle for fifo_lane_adder: FWFT input FIFO read port and output FIFO write port.
// master is the adder side (pops and pushes), slave is the FIFO/environment side.
interface fifo_lane_adder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  data_empty;
  logic                  data_rd;
  logic [DATA_WIDTH-1:0] data_din;
  logic                  data_full;
  logic                  data_wr;
  logic [DATA_WIDTH-1:0] data_dout;

  modport master (
    input  data_empty,
    input  data_din,
    input  data_full,
    output data_rd,
    output data_wr,
    output data_dout
  );

  modport slave (
    output data_empty,
    output data_din,
    output data_full,
    input  data_rd,
    input  data_wr,
    input  data_dout
  );
endinterface

// File: rtl/fifo_lane_adder.sv
// Pops a word from an FWFT FIFO, adds/subtracts/saturate-adds LANES operand pairs, pushes packed results.
// Three-state FSM (IDLE -> CALC -> WRITE) with every output registered; one word per three cycles.
module fifo_lane_adder #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int LANES      = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  fifo_lane_adder_if.master      bus,
  input  logic [1:0]             mode,
  output logic                   busy,
  output logic [15:0]            result_count
);

  localparam int OPS_BITS = 2 * LANES * OP_WIDTH;
  localparam int RES_W    = OP_WIDTH + 1;
  localparam int RES_BITS = LANES * RES_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [OPS_BITS-1:0] operand_q;
  logic [1:0]          mode_q;
  logic [RES_BITS-1:0] result_q;
  logic [RES_BITS-1:0] lane_result;
  logic                rd_next;
  logic                wr_next;
  logic                capture_en;
  logic                calc_en;
  logic                write_en;

  // Upper input bits carry no operands; reduce them into a deliberately unused net.
  if (DATA_WIDTH > OPS_BITS) begin : g_unused_din
    logic unused_din_bits;
    assign unused_din_bits = ^bus.data_din[DATA_WIDTH-1:OPS_BITS];
  end

  // Per-lane arithmetic works from the captured word and mode, so input changes after capture are ignored.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [OP_WIDTH-1:0] op_a;
    logic [OP_WIDTH-1:0] op_b;
    logic [RES_W-1:0]    sum;
    logic [RES_W-1:0]    diff;
    logic [RES_W-1:0]    sat;
    logic [RES_W-1:0]    res;

    assign op_a = operand_q[(2*g)*OP_WIDTH +: OP_WIDTH];
    assign op_b = operand_q[(2*g+1)*OP_WIDTH +: OP_WIDTH];
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};
    assign sat  = sum[OP_WIDTH] ? {1'b0, {OP_WIDTH{1'b1}}} : sum;

    always_comb begin
      res = sum;
      case (mode_q)
        2'b01:   res = diff;
        2'b10:   res = sat;
        default: res = sum;
      endcase
    end

    assign lane_result[g*RES_W +: RES_W] = res;
  end

  always_comb begin
    state_next = state;
    rd_next    = 1'b0;
    wr_next    = 1'b0;
    capture_en = 1'b0;
    calc_en    = 1'b0;
    write_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.data_empty) begin
          rd_next    = 1'b1;
          capture_en = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        calc_en    = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        if (!bus.data_full) begin
          wr_next    = 1'b1;
          write_en   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset wins over everything, so a word caught in CALC or WRITE is simply dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      bus.data_rd   <= 1'b0;
      bus.data_wr   <= 1'b0;
      bus.data_dout <= '0;
      result_count  <= '0;
      busy          <= 1'b0;
      operand_q     <= '0;
      mode_q        <= '0;
      result_q      <= '0;
    end else begin
      state       <= state_next;
      bus.data_rd <= rd_next;
      bus.data_wr <= wr_next;
      busy        <= (state_next != IDLE);
      if (capture_en) begin
        operand_q <= bus.data_din[OPS_BITS-1:0];
        mode_q    <= mode;
      end
      if (calc_en) begin
        result_q <= lane_result;
      end
      if (write_en) begin
        bus.data_dout <= DATA_WIDTH'(result_q);
        result_count  <= result_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_lane_adder.sv
// Scoreboard bench for fifo_lane_adder: a FWFT FIFO model feeds words, a monitor checks each push.
// Expected results are hand-computed constants queued alongside the stimulus.
module tb_fifo_lane_adder;

  localparam int DW = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode;
  logic        busy;
  logic [15:0] result_count;

  fifo_lane_adder_if #(.DATA_WIDTH(DW)) bus_if ();

  fifo_lane_adder #(
    .DATA_WIDTH (DW),
    .OP_WIDTH   (4),
    .LANES      (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus_if.master),
    .mode         (mode),
    .busy         (busy),
    .result_count (result_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  op_mode;
  } in_t;

  typedef struct {
    logic [31:0] dout;
    logic [15:0] count;
  } exp_t;

  in_t         in_q[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_count = '0;
  int          cycle = 0;
  int          last_rd_cycle = 0;
  int          prev_rd_cycle = 0;
  int          wr_total = 0;
  bit          stall_seen = 1'b0;
  bit          spacing_check = 1'b0;
  bit          have_prev_rd = 1'b0;
  logic        full_at_edge = 1'b0;
  logic [1:0]  last_mode = 2'b00;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word, input logic [1:0] op_mode,
                               input logic [31:0] dout_exp, input bit expect_write);
    if (expect_write) begin
      exp_count = exp_count + 16'd1;
      exp_q.push_back('{dout_exp, exp_count});
    end
    in_q.push_back('{word, op_mode});
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0 || busy) && n < 300) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(n >= 300), 32'd0);
    @(negedge clock);
  endtask

  task automatic waitRd(input string name);
    int n = 0;
    while (!bus_if.data_rd && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 32'(n >= 50), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rd"}, 32'(bus_if.data_rd), 32'd0);
    checkOutput({tag, "_wr"}, 32'(bus_if.data_wr), 32'd0);
    checkOutput({tag, "_dout"}, bus_if.data_dout, 32'd0);
    checkOutput({tag, "_count"}, 32'(result_count), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Input FIFO model: pops on a registered data_rd, presents the head word; mode flips once the FIFO drains.
  initial begin
    bus_if.data_empty = 1'b1;
    bus_if.data_din   = 32'hA5A5_A5A5;
    bus_if.data_full  = 1'b0;
    mode              = 2'b00;
    forever begin
      @(negedge clock);
      if (bus_if.data_rd) begin
        checkOutput("rd_while_empty", 32'(in_q.size() == 0), 32'd0);
        if (in_q.size() != 0) in_q.delete(0);
      end
      if (in_q.size() != 0) begin
        bus_if.data_empty = 1'b0;
        bus_if.data_din   = in_q[0].word;
        mode              = in_q[0].op_mode;
        last_mode         = in_q[0].op_mode;
      end else begin
        bus_if.data_empty = 1'b1;
        bus_if.data_din   = 32'hA5A5_A5A5;
        mode              = last_mode ^ 2'b01;
      end
    end
  end

  always @(posedge clock) begin
    full_at_edge = bus_if.data_full;
    if (bus_if.data_full) stall_seen = 1'b1;
  end

  // Monitor: every push is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cycle++;
      if (bus_if.data_rd) begin
        if (spacing_check && have_prev_rd)
          checkOutput("rd_spacing", 32'(cycle - prev_rd_cycle), 32'd3);
        have_prev_rd  = 1'b1;
        prev_rd_cycle = cycle;
        last_rd_cycle = cycle;
        stall_seen    = 1'b0;
      end
      if (bus_if.data_wr) begin
        wr_total++;
        checkOutput("wr_while_full", 32'(full_at_edge), 32'd0);
        if (!stall_seen)
          checkOutput("rd_to_wr_latency", 32'(cycle - last_rd_cycle), 32'd2);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_wr: got dout 0x%08h with no expected word queued", bus_if.data_dout);
        end else begin
          e = exp_q.pop_front();
          checkOutput("dout", bus_if.data_dout, e.dout);
          checkOutput("result_count", 32'(result_count), 32'(e.count));
        end
      end
    end
  end

  initial begin
    int wr_start;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checkResetState("reset");
    reset_n = 1'b1;
    @(negedge clock);

    applyStimulus(32'h0000_4321, 2'b00, 32'h0000_00E3, 1'b1);
    waitDrain("drain_basic");
    checkOutput("dout_hold", bus_if.data_dout, 32'h0000_00E3);

    applyStimulus(32'h0000_4321, 2'b01, 32'h0000_03FF, 1'b1);
    applyStimulus(32'h0000_00FF, 2'b00, 32'h0000_001E, 1'b1);
    applyStimulus(32'h0000_00FF, 2'b10, 32'h0000_000F, 1'b1);
    applyStimulus(32'h0000_4321, 2'b11, 32'h0000_00E3, 1'b1);
    applyStimulus(32'h0000_A5C3, 2'b10, 32'h0000_01EF, 1'b1);
    applyStimulus(32'h0000_A5C3, 2'b01, 32'h0000_0377, 1'b1);
    applyStimulus(32'hDEAD_98F7, 2'b10, 32'h0000_01EF, 1'b1);
    applyStimulus(32'hDEAD_98F7, 2'b00, 32'h0000_0236, 1'b1);
    applyStimulus(32'h0000_5519, 2'b01, 32'h0000_0008, 1'b1);
    waitDrain("drain_vectors");

    // Output FIFO full while the result waits in WRITE.
    bus_if.data_full = 1'b1;
    applyStimulus(32'h0000_7777, 2'b00, 32'h0000_01CE, 1'b1);
    waitRd("hold_rd_timeout");
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_wr", 32'(bus_if.data_wr), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
      @(negedge clock);
    end
    bus_if.data_full = 1'b0;
    @(negedge clock);
    checkOutput("wr_after_release", 32'(bus_if.data_wr), 32'd1);
    waitDrain("drain_hold");

    // Reset while the word sits in CALC: it must vanish without a push.
    applyStimulus(32'h0000_1234, 2'b00, 32'h0, 1'b0);
    waitRd("abort_rd_timeout");
    reset_n = 1'b0;
    @(negedge clock);
    checkResetState("abort");
    reset_n   = 1'b1;
    exp_count = '0;
    repeat (5) @(negedge clock);
    checkOutput("abort_idle_busy", 32'(busy), 32'd0);
    applyStimulus(32'h0000_4321, 2'b00, 32'h0000_00E3, 1'b1);
    waitDrain("drain_after_abort");

    spacing_check = 1'b1;
    have_prev_rd  = 1'b0;
    wr_start      = wr_total;
    applyStimulus(32'h0000_1111, 2'b00, 32'h0000_0042, 1'b1);
    applyStimulus(32'h0000_2222, 2'b00, 32'h0000_0084, 1'b1);
    applyStimulus(32'h0000_3333, 2'b01, 32'h0000_0000, 1'b1);
    applyStimulus(32'h0000_F0F0, 2'b10, 32'h0000_01EF, 1'b1);
    waitDrain("drain_b2b");
    spacing_check = 1'b0;
    checkOutput("b2b_writes", 32'(wr_total - wr_start), 32'd4);
    checkOutput("b2b_count", 32'(result_count), 32'(exp_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at time %0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
